// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared encodings for the register bank.
// Holds the op codes, the branch-condition codes carried on rd[1:0]
// and the two-state FSM encoding used by reg_bank.
package reg_bank_pkg;

  typedef logic [1:0] op_t;
  localparam op_t OP_NONE   = 2'b00;
  localparam op_t OP_READ   = 2'b01;
  localparam op_t OP_BRANCH = 2'b10;
  localparam op_t OP_RSVD   = 2'b11;

  typedef logic [1:0] br_cond_t;
  localparam br_cond_t BR_ZF  = 2'b00;
  localparam br_cond_t BR_NZF = 2'b10;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_CLEAR = 1'b1;

endpackage

// File: rtl/reg_bank_cell.sv
// reg_bank_cell: one DW-wide storage register.
// Synchronous clear takes priority over the load enable, so the clear
// sequencer can zero a cell even if a load is requested in the same cycle.
module reg_bank_cell #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ld,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  // Storage update: reset/clear zero the cell, otherwise load on enable
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// reg_bank: small general-register bank with two registered read ports,
// a zero flag with a registered branch decision, and a sequential clear
// that zeroes one register per cycle.
// Build option: define REG_BANK_BYPASS_EN to forward same-cycle write data
// to a read of the same address; without it such a read sees the old value.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DW      = 16,
  parameter int NREG    = 4,
  parameter int R0_ZERO = 0,
  localparam int AW     = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    op,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          zf_we,
  input  logic          zf_d,
  input  logic          clr,
  output logic [DW-1:0] rd_q,
  output logic [DW-1:0] rs_q,
  output logic          q_valid,
  output logic          zf_ctrl,
  output logic          br_valid,
  output logic          busy
);

  state_t        state;
  logic [AW-1:0] clr_idx;
  logic          zf;
  logic          idle;
  logic          wr_fire;
  logic [1:0]    br_cond;
  logic [DW-1:0] rd_val;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] reg_q [NREG];

  assign idle    = (state == ST_IDLE);
  assign busy    = (state == ST_CLEAR);
  assign wr_fire = idle && wr_en && !clr;

  // With only two registers rd is a single bit, so the condition code is
  // zero-extended; otherwise the low two bits of rd select the condition.
  if (AW >= 2) begin : g_cond_wide
    assign br_cond = rd[1:0];
  end else begin : g_cond_narrow
    assign br_cond = {1'b0, rd};
  end

  for (genvar i = 0; i < NREG; i++) begin : g_cell
    logic cell_clr;
    logic cell_ld;
    assign cell_clr = busy && (clr_idx == AW'(i));
    assign cell_ld  = wr_fire && (wr_addr == AW'(i)) && !((R0_ZERO != 0) && (i == 0));
    reg_bank_cell #(.DW(DW)) u_cell (
      .clk (clk),
      .rst (rst),
      .clr (cell_clr),
      .ld  (cell_ld),
      .d   (wr_data),
      .q   (reg_q[i])
    );
  end

  // Read-port data selection including optional write forwarding and the
  // hard-wired zero register
  always_comb begin
    rd_val = reg_q[rd];
    rs_val = reg_q[rs];
`ifdef REG_BANK_BYPASS_EN
    if (wr_fire && (wr_addr == rd)) rd_val = wr_data;
    if (wr_fire && (wr_addr == rs)) rs_val = wr_data;
`endif
    if ((R0_ZERO != 0) && (rd == '0)) rd_val = '0;
    if ((R0_ZERO != 0) && (rs == '0)) rs_val = '0;
  end

  // Clear sequencer: walk clr_idx from 0 to NREG-1, then return to idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      clr_idx <= '0;
    end else if (idle) begin
      if (clr) begin
        state   <= ST_CLEAR;
        clr_idx <= '0;
      end
    end else begin
      if (clr_idx == AW'(NREG - 1)) state <= ST_IDLE;
      clr_idx <= clr_idx + 1'b1;
    end
  end

  // Zero flag: only written while idle, untouched by the clear sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      zf <= 1'b0;
    end else if (idle && zf_we) begin
      zf <= zf_d;
    end
  end

  // Registered read ports: capture on an accepted read, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      rs_q    <= '0;
      q_valid <= 1'b0;
    end else if (idle && (op == OP_READ)) begin
      rd_q    <= rd_val;
      rs_q    <= rs_val;
      q_valid <= 1'b1;
    end else begin
      q_valid <= 1'b0;
    end
  end

  // Branch decision from the pre-update zero flag; drops to 0 otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      zf_ctrl  <= 1'b0;
      br_valid <= 1'b0;
    end else if (idle && (op == OP_BRANCH)) begin
      br_valid <= 1'b1;
      case (br_cond)
        BR_ZF:   zf_ctrl <= zf;
        BR_NZF:  zf_ctrl <= ~zf;
        default: zf_ctrl <= 1'b0;
      endcase
    end else begin
      zf_ctrl  <= 1'b0;
      br_valid <= 1'b0;
    end
  end

endmodule
